// File: rtl/regread_stage_if.sv
// Shared types and the two stage-boundary interfaces around the register-read stage.
package regread_types_pkg;
  typedef struct packed {
    logic [3:0] unit;
    logic [3:0] code;
  } op_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } trap_info_t;
endpackage

// Decode -> register-read boundary. Decode drives through this_stage,
// the register-read stage consumes through next_stage.
interface decode_stage_if;
  import regread_types_pkg::*;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] insn;
  op_t         op;
  logic [11:0] csrAddr;
  trap_info_t  trapInfo;

  modport this_stage (output valid, pc, insn, op, csrAddr, trapInfo);
  modport next_stage (input  valid, pc, insn, op, csrAddr, trapInfo);
endinterface

// Register-read -> execute boundary. All fields are registered in the
// register-read stage; execute consumes through next_stage.
interface regread_stage_if;
  import regread_types_pkg::*;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] insn;
  op_t         op;
  logic [11:0] csrAddr;
  trap_info_t  trapInfo;
  logic [31:0] srcRegValue1;
  logic [31:0] srcRegValue2;

  modport this_stage (output valid, pc, insn, op, csrAddr, trapInfo,
                      srcRegValue1, srcRegValue2);
  modport next_stage (input  valid, pc, insn, op, csrAddr, trapInfo,
                      srcRegValue1, srcRegValue2);
endinterface

// File: rtl/regread_stage.sv
// Register-read pipeline stage: latches the decoded instruction, reads both
// source operands (with write-back bypass on capture and operand refresh
// while stalled) and presents a registered bundle to execute.
// Flow control: there is no valid/ready pair here. A bundle moves forward on
// every edge where stall=0; flush drops valid; the controller stalls decode
// together with this stage, so nothing is ever lost on the input side.
module regread_stage
  import regread_types_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  decode_stage_if.next_stage          prev,
  regread_stage_if.this_stage         next,
  output logic [4:0]                  rfReadAddr1,
  output logic [4:0]                  rfReadAddr2,
  input  logic [31:0]                 rfReadValue1,
  input  logic [31:0]                 rfReadValue2,
  input  logic                        wbEnable,
  input  logic [4:0]                  wbAddr,
  input  logic [31:0]                 wbValue,
  input  logic                        stall,
  input  logic                        flush
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  op_t         op_q, op_d;
  logic [11:0] csr_q, csr_d;
  trap_info_t  trap_q, trap_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;

  logic [4:0]  rs1_new, rs2_new;
  logic [31:0] cap1, cap2;

  // Read addresses come straight from the incoming instruction, independent of stall.
  assign rs1_new     = prev.insn[19:15];
  assign rs2_new     = prev.insn[24:20];
  assign rfReadAddr1 = rs1_new;
  assign rfReadAddr2 = rs2_new;

  // Operand values for a capture: x0 reads zero, a same-cycle write-back wins
  // over the register file (whose async read still returns the old value).
  always_comb begin
    cap1 = rfReadValue1;
    cap2 = rfReadValue2;
    if (rs1_new == 5'd0) begin
      cap1 = '0;
    end else if (wbEnable && (wbAddr == rs1_new)) begin
      cap1 = wbValue;
    end
    if (rs2_new == 5'd0) begin
      cap2 = '0;
    end else if (wbEnable && (wbAddr == rs2_new)) begin
      cap2 = wbValue;
    end
  end

  // Next-state selection: flush kills, stall holds (refreshing operands), else advance.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    op_d    = op_q;
    csr_d   = csr_q;
    trap_d  = trap_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      if (valid_q && wbEnable && (wbAddr == rs1_q) && (rs1_q != 5'd0)) begin
        src1_d = wbValue;
      end
      if (valid_q && wbEnable && (wbAddr == rs2_q) && (rs2_q != 5'd0)) begin
        src2_d = wbValue;
      end
    end else begin
      valid_d = prev.valid;
      pc_d    = prev.pc;
      insn_d  = prev.insn;
      op_d    = prev.op;
      csr_d   = prev.csrAddr;
      trap_d  = prev.trapInfo;
      src1_d  = cap1;
      src2_d  = cap2;
      rs1_d   = rs1_new;
      rs2_d   = rs2_new;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      insn_q  <= '0;
      op_q    <= '0;
      csr_q   <= '0;
      trap_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      op_q    <= op_d;
      csr_q   <= csr_d;
      trap_q  <= trap_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign next.valid        = valid_q;
  assign next.pc           = pc_q;
  assign next.insn         = insn_q;
  assign next.op           = op_q;
  assign next.csrAddr      = csr_q;
  assign next.trapInfo     = trap_q;
  assign next.srcRegValue1 = src1_q;
  assign next.srcRegValue2 = src2_q;

endmodule

// File: tb/tb_regread_stage.sv
// Bench for regread_stage: directed scenarios plus a randomized run, all
// checked against an architectural model (register-file array + expected bundle).
module tb_regread_stage;
  import regread_types_pkg::*;

  localparam int BW = 154;

  logic        clk;
  logic        rst;
  logic [4:0]  rfReadAddr1, rfReadAddr2;
  logic [31:0] rf1, rf2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_val;
  logic        stall, flush;

  decode_stage_if  prev_if ();
  regread_stage_if next_if ();

  regread_stage dut (
    .clk          (clk),
    .rst          (rst),
    .prev         (prev_if.next_stage),
    .next         (next_if.this_stage),
    .rfReadAddr1  (rfReadAddr1),
    .rfReadAddr2  (rfReadAddr2),
    .rfReadValue1 (rf1),
    .rfReadValue2 (rf2),
    .wbEnable     (wb_en),
    .wbAddr       (wb_addr),
    .wbValue      (wb_val),
    .stall        (stall),
    .flush        (flush)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  // Index 0 may hold garbage on purpose: the stage must force x0 to zero.
  logic [31:0] rf_regs [32];
  always_comb rf1 = rf_regs[prev_if.insn[19:15]];
  always_comb rf2 = rf_regs[prev_if.insn[24:20]];

  // ---------------- expected bundle ----------------
  logic        exp_valid;
  logic [31:0] exp_pc, exp_insn, exp_src1, exp_src2;
  op_t         exp_op;
  logic [11:0] exp_csr;
  trap_info_t  exp_trap;
  logic [4:0]  exp_rs1, exp_rs2;
  logic        exp_dc;   // fields other than valid are don't-care after a flush

  int errors = 0;
  int checks = 0;

  function automatic logic [BW-1:0] dut_bundle();
    return {next_if.valid, next_if.pc, next_if.insn, next_if.op, next_if.csrAddr,
            next_if.trapInfo, next_if.srcRegValue1, next_if.srcRegValue2};
  endfunction

  function automatic logic [BW-1:0] exp_bundle();
    return {exp_valid, exp_pc, exp_insn, exp_op, exp_csr, exp_trap, exp_src1, exp_src2};
  endfunction

  // Architectural value of register r as seen by an instruction.
  function automatic logic [31:0] arch_reg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : rf_regs[r];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_prev(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                            input logic [7:0] op, input logic [11:0] csr, input logic [4:0] trap);
    prev_if.valid    = v;
    prev_if.pc       = pc;
    prev_if.insn     = insn;
    prev_if.op       = op;
    prev_if.csrAddr  = csr;
    prev_if.trapInfo = trap;
  endtask

  task automatic drive_ctl(input logic r, input logic s, input logic f,
                           input logic we, input logic [4:0] wa, input logic [31:0] wv);
    rst = r; stall = s; flush = f; wb_en = we; wb_addr = wa; wb_val = wv;
  endtask

  // One clock edge, then advance the model from the inputs that were presented.
  // Write-back retires into the architectural file first; a captured or stalled
  // instruction's operands must then agree with that architectural state.
  task automatic tick();
    logic wb_hit1, wb_hit2;
    @(posedge clk);
    #1;
    wb_hit1 = wb_en && (wb_addr == exp_rs1);
    wb_hit2 = wb_en && (wb_addr == exp_rs2);
    if (wb_en && wb_addr != 5'd0) rf_regs[wb_addr] = wb_val;
    if (rst) begin
      exp_valid = 0; exp_pc = 0; exp_insn = 0; exp_op = '0; exp_csr = 0; exp_trap = '0;
      exp_src1 = 0; exp_src2 = 0; exp_rs1 = 0; exp_rs2 = 0; exp_dc = 0;
    end else if (flush) begin
      exp_valid = 0;
      exp_dc    = 1;
    end else if (stall) begin
      if (exp_valid && wb_hit1) exp_src1 = arch_reg(exp_rs1);
      if (exp_valid && wb_hit2) exp_src2 = arch_reg(exp_rs2);
    end else begin
      exp_valid = prev_if.valid;
      exp_pc    = prev_if.pc;
      exp_insn  = prev_if.insn;
      exp_op    = prev_if.op;
      exp_csr   = prev_if.csrAddr;
      exp_trap  = prev_if.trapInfo;
      exp_rs1   = prev_if.insn[19:15];
      exp_rs2   = prev_if.insn[24:20];
      exp_src1  = arch_reg(exp_rs1);
      exp_src2  = arch_reg(exp_rs2);
      exp_dc    = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf_regs[i] = $urandom;
    drive_prev(1'b1, 32'h0000_0400, 32'h0020_81B3, 8'h12, 12'h300, 5'h13);
    drive_ctl(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'hABCD);
    tick();
    tick();
    checks++;
    if (dut_bundle() !== '0) begin
      errors++;
      $display("FAIL reset_zero: got %h expected 0", dut_bundle());
    end
    checks++;
    if (dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", dut_bundle(), exp_bundle());
    end
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (next_if.valid !== 1'b1 || next_if.pc !== 32'h0000_0400 || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL reset_first_capture: got %h expected %h", dut_bundle(), exp_bundle());
    end
  endtask

  task automatic test_pass_through();
    rf_regs[1] = 32'd5;
    rf_regs[2] = 32'd7;
    drive_prev(1'b1, 32'h100, 32'h0020_81B3, 8'h01, 12'h000, 5'h00);
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (rfReadAddr1 !== 5'd1 || rfReadAddr2 !== 5'd2) begin
      errors++;
      $display("FAIL pass_rf_addr: got %0d/%0d expected 1/2", rfReadAddr1, rfReadAddr2);
    end
    tick();
    checks++;
    if (next_if.pc !== 32'h100 || next_if.srcRegValue1 !== 32'd5 || next_if.srcRegValue2 !== 32'd7
        || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL pass_through: got %h expected %h", dut_bundle(), exp_bundle());
    end
  endtask

  task automatic test_x0_bypass();
    rf_regs[0] = 32'hDEAD;
    rf_regs[2] = 32'h11;
    drive_prev(1'b1, 32'h104, 32'h0020_01B3, 8'h01, 12'h000, 5'h00);
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h55);
    tick();
    checks++;
    if (next_if.srcRegValue1 !== 32'd0 || next_if.srcRegValue2 !== 32'h55
        || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL x0_bypass: got %h expected %h", dut_bundle(), exp_bundle());
    end
  endtask

  task automatic test_stall_refresh();
    rf_regs[1] = 32'd5;
    rf_regs[2] = 32'd7;
    drive_prev(1'b1, 32'h200, 32'h0020_81B3, 8'h01, 12'h000, 5'h00);
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    // Decode moves on to something else while this stage is stalled.
    drive_prev(1'b1, 32'h204, 32'h0031_0233, 8'h02, 12'h000, 5'h00);
    drive_ctl(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (next_if.pc !== 32'h200 || next_if.srcRegValue1 !== 32'd5 || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL stall_hold: got %h expected %h", dut_bundle(), exp_bundle());
    end
    drive_ctl(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h99);
    tick();
    checks++;
    if (next_if.srcRegValue1 !== 32'h99 || next_if.srcRegValue2 !== 32'd7 || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL stall_refresh: got %h expected %h", dut_bundle(), exp_bundle());
    end
    drive_ctl(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1);
    tick();
    checks++;
    if (next_if.srcRegValue1 !== 32'h99 || next_if.srcRegValue2 !== 32'd7 || next_if.pc !== 32'h200
        || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL stall_x0_write: got %h expected %h", dut_bundle(), exp_bundle());
    end
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (next_if.pc !== 32'h204 || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", dut_bundle(), exp_bundle());
    end
  endtask

  task automatic test_flush_priority();
    drive_prev(1'b1, 32'h300, 32'h0020_81B3, 8'h03, 12'h000, 5'h00);
    drive_ctl(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (next_if.valid !== 1'b0 || next_if.valid !== exp_valid) begin
      errors++;
      $display("FAIL flush_over_stall: got valid=%b expected valid=0", next_if.valid);
    end
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (next_if.valid !== 1'b1 || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL flush_then_accept: got %h expected %h", dut_bundle(), exp_bundle());
    end
  endtask

  task automatic test_trap_bubble();
    drive_prev(1'b1, 32'h400, 32'h0000_0073, 8'hA5, 12'h305, {1'b1, 4'd2});
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (next_if.trapInfo !== {1'b1, 4'd2} || next_if.csrAddr !== 12'h305 || next_if.valid !== 1'b1
        || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL trap_pass: got %h expected %h", dut_bundle(), exp_bundle());
    end
    drive_prev(1'b0, 32'h404, 32'h0020_81B3, 8'h00, 12'h000, 5'h00);
    tick();
    checks++;
    if (next_if.valid !== 1'b0 || dut_bundle() !== exp_bundle()) begin
      errors++;
      $display("FAIL bubble: got %h expected %h", dut_bundle(), exp_bundle());
    end
  endtask

  task automatic test_random();
    logic [31:0] insn;
    for (int n = 0; n < 400; n++) begin
      insn = $urandom;
      insn[19:15] = 5'($urandom_range(0, 3));
      insn[24:20] = 5'($urandom_range(0, 3));
      drive_prev(1'($urandom_range(0, 3) != 0), $urandom, insn, 8'($urandom),
                 12'($urandom), 5'($urandom));
      drive_ctl(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 3),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), $urandom);
      #1;
      checks++;
      if (rfReadAddr1 !== insn[19:15] || rfReadAddr2 !== insn[24:20]) begin
        errors++;
        $display("FAIL rand_rf_addr[%0d]: got %0d/%0d expected %0d/%0d", n,
                 rfReadAddr1, rfReadAddr2, insn[19:15], insn[24:20]);
      end
      tick();
      checks++;
      if (exp_dc ? (next_if.valid !== exp_valid) : (dut_bundle() !== exp_bundle())) begin
        errors++;
        $display("FAIL rand_bundle[%0d]: got %h expected %h", n, dut_bundle(), exp_bundle());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    exp_valid = 0; exp_pc = 0; exp_insn = 0; exp_op = '0; exp_csr = 0; exp_trap = '0;
    exp_src1 = 0; exp_src2 = 0; exp_rs1 = 0; exp_rs2 = 0; exp_dc = 0;
    drive_prev(1'b0, 32'd0, 32'd0, 8'd0, 12'd0, 5'd0);
    drive_ctl(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    test_reset();
    test_pass_through();
    test_x0_bypass();
    test_stall_refresh();
    test_flush_priority();
    test_trap_bubble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
